vehicle_status_conditioner: RTL and testbench
=============================================

Name: vehicle_status_conditioner

Overview:
Upstream conditioning stage for the vehicle safety-control logic. It converts raw sensor samples (CPU temperature, fuel level, distance ticks) into the clean, registered status flags that the safety logic consumes: cpu_overheated, gas_tank_empty and arrived. Each flag is filtered with hysteresis and a persistence count so that single noisy samples cannot toggle the shut-off or keep-driving decisions. A trip state machine tracks the remaining distance to the loaded destination.

Parameters:
HOT_ON, 90, temperature (°C) at or above which a sample counts as hot
HOT_OFF, 80, temperature at or below which a sample counts as cool; must be < HOT_ON
TEMP_CNT, 3, consecutive qualifying temperature samples needed to change cpu_overheated; >= 1
FUEL_EMPTY, 10, fuel level at or below which a sample counts as empty
FUEL_REFILL, 20, fuel level at or above which a sample counts as refilled; must be > FUEL_EMPTY
FUEL_CNT, 4, consecutive qualifying fuel samples needed to change gas_tank_empty; >= 1
DIST_W, 16, width of the distance counter

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
temp_valid  input  1  temp_c holds a new sample this cycle
temp_c  input  8  unsigned CPU temperature, °C
fuel_valid  input  1  fuel_level holds a new sample this cycle
fuel_level  input  8  unsigned fuel level, 0..255
dist_tick  input  1  one-cycle pulse per distance unit travelled
dest_load  input  1  load a new destination distance
dest_dist  input  DIST_W  distance to the new destination
cpu_overheated  output  1  filtered overheat flag
gas_tank_empty  output  1  filtered empty-tank flag
arrived  output  1  high when no trip is active or the trip is complete
remaining_dist  output  DIST_W  distance units left in the current trip

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - cpu_overheated=0
  - gas_tank_empty=1 (safe default: no driving until fuel is confirmed)
  - arrived=1
  - remaining_dist=0
  - All persistence counters=0
  - Trip FSM=IDLE
- Reset asserted mid-operation overrides every other input in that cycle.
- All outputs are registered. Zero combinational paths from inputs to outputs.
- Overheat filter:
  - Samples are considered only when temp_valid=1. Cycles with temp_valid=0 leave the counter and flag unchanged.
  - While cpu_overheated=0: a valid sample with temp_c>=HOT_ON increments hot_cnt; any other valid sample clears hot_cnt.
  - When a qualifying sample would bring hot_cnt to TEMP_CNT, cpu_overheated is set on that same clock edge and hot_cnt clears.
  - While cpu_overheated=1: the mirror rule applies, using temp_c<=HOT_OFF to clear the flag.
  - Samples strictly between HOT_OFF and HOT_ON always clear the counter and never change the flag.
  - The counter saturates and never wraps.
- Fuel filter: identical structure using fuel_valid, FUEL_CNT, the empty rule fuel_level<=FUEL_EMPTY and the refilled rule fuel_level>=FUEL_REFILL.
  - Starting from reset (gas_tank_empty=1), FUEL_CNT refilled samples are needed to clear the flag.
- Trip FSM, states IDLE, TRIP and DONE:
  - arrived=0 only in TRIP; arrived=1 in IDLE and DONE.
  - dest_load=1 in any state: remaining_dist<=dest_dist.
    - Next state is TRIP if dest_dist!=0.
    - Next state is DONE if dest_dist==0; in that case arrived stays 1 and never dips.
  - In TRIP, dist_tick=1 decrements remaining_dist.
    - When the decrement reaches 0, the FSM enters DONE on the same edge, and arrived=1 from the next cycle.
  - dest_load together with dist_tick in the same cycle: the load wins and the tick is discarded.
  - dist_tick in IDLE or DONE is ignored; remaining_dist holds its value, with no underflow.
  - A DONE to TRIP transition requires a new dest_load.
- All three filters and the FSM are independent and may update in the same cycle.

Test Plan:
- Reset, then idle 5 cycles -> cpu_overheated=0, gas_tank_empty=1, arrived=1, remaining_dist=0.
- Temperature persistence and hysteresis:
  - Valid temp sequence 95,95,85,95,95,95 -> cpu_overheated rises only at the edge sampling the final 95 (the 85 resets the count).
  - Then 79,79,79 -> the flag falls at the third 79.
  - The sequence 85,85,85,85 never changes the flag.
- Fuel refill and empty, with gaps:
  - fuel_valid pulses with level 25 four times, with temp_valid/fuel_valid gaps of 0 in between -> gas_tank_empty falls at the 4th sample.
  - Then level 10 ×3 -> still 0; a 4th sample at 10 -> rises to 1.
- Trip countdown:
  - dest_load with dest_dist=3 -> arrived=0 and remaining_dist=3 next cycle.
  - 3 dist_tick pulses -> remaining_dist 2,1,0, arrived=1 after the 3rd.
  - An extra tick -> remaining_dist stays 0.
- Load/tick collision:
  - In TRIP with remaining_dist=5, assert dest_load (dest_dist=7) and dist_tick together -> remaining_dist=7, not 6.
  - A later dest_load with dest_dist=0 -> DONE immediately, arrived=1.
- Reset mid-trip and mid-count:
  - remaining_dist=4 with hot_cnt=2, then reset asserted for one cycle -> all outputs return to reset values.
  - A subsequent single 95 sample does not set cpu_overheated.

Source files
------------

// File: rtl/vehicle_status_conditioner.sv
// Filters raw temperature/fuel samples into hysteresis+persistence flags and tracks trip distance.
// Latency 1 cycle, all outputs registered; no backpressure, every sample is consumed when valid.
module vehicle_status_conditioner #(
  parameter int HOT_ON      = 90,
  parameter int HOT_OFF     = 80,
  parameter int TEMP_CNT    = 3,
  parameter int FUEL_EMPTY  = 10,
  parameter int FUEL_REFILL = 20,
  parameter int FUEL_CNT    = 4,
  parameter int DIST_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              temp_valid,
  input  logic [7:0]        temp_c,
  input  logic              fuel_valid,
  input  logic [7:0]        fuel_level,
  input  logic              dist_tick,
  input  logic              dest_load,
  input  logic [DIST_W-1:0] dest_dist,
  output logic              cpu_overheated,
  output logic              gas_tank_empty,
  output logic              arrived,
  output logic [DIST_W-1:0] remaining_dist
);

  localparam int TW = $clog2(TEMP_CNT + 1);
  localparam int FW = $clog2(FUEL_CNT + 1);

  typedef enum logic [1:0] {IDLE, TRIP, DONE} trip_state_t;

  logic [TW-1:0]     hot_cnt;
  logic [FW-1:0]     fuel_cnt;
  logic              temp_qual;
  logic              fuel_qual;
  trip_state_t       state;
  trip_state_t       state_nx;
  logic [DIST_W-1:0] rem_nx;

  // A qualifying sample is one that argues for flipping the current flag.
  always_comb begin
    temp_qual = cpu_overheated ? (temp_c <= 8'(HOT_OFF)) : (temp_c >= 8'(HOT_ON));
    fuel_qual = gas_tank_empty ? (fuel_level >= 8'(FUEL_REFILL))
                               : (fuel_level <= 8'(FUEL_EMPTY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hot_cnt        <= '0;
      cpu_overheated <= 1'b0;
    end else if (temp_valid) begin
      if (!temp_qual) begin
        hot_cnt <= '0;
      end else if (hot_cnt >= TW'(TEMP_CNT - 1)) begin
        cpu_overheated <= ~cpu_overheated;
        hot_cnt        <= '0;
      end else begin
        hot_cnt <= hot_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fuel_cnt       <= '0;
      gas_tank_empty <= 1'b1;
    end else if (fuel_valid) begin
      if (!fuel_qual) begin
        fuel_cnt <= '0;
      end else if (fuel_cnt >= FW'(FUEL_CNT - 1)) begin
        gas_tank_empty <= ~gas_tank_empty;
        fuel_cnt       <= '0;
      end else begin
        fuel_cnt <= fuel_cnt + 1'b1;
      end
    end
  end

  // A load always beats a simultaneous tick; a zero-length load goes straight to DONE.
  always_comb begin
    state_nx = state;
    rem_nx   = remaining_dist;
    if (dest_load) begin
      rem_nx   = dest_dist;
      state_nx = (dest_dist != '0) ? TRIP : DONE;
    end else if (state == TRIP && dist_tick) begin
      rem_nx = remaining_dist - 1'b1;
      if (remaining_dist == DIST_W'(1)) begin
        state_nx = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      remaining_dist <= '0;
      arrived        <= 1'b1;
    end else begin
      state          <= state_nx;
      remaining_dist <= rem_nx;
      arrived        <= (state_nx != TRIP);
    end
  end

endmodule

// File: tb/tb_vehicle_status_conditioner.sv
// Bench for vehicle_status_conditioner: directed scenarios then random traffic against a reference model.
module tb_vehicle_status_conditioner;

  localparam int HOT_ON = 90, HOT_OFF = 80, TEMP_CNT = 3;
  localparam int FUEL_EMPTY = 10, FUEL_REFILL = 20, FUEL_CNT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        temp_valid = 1'b0;
  logic [7:0]  temp_c = '0;
  logic        fuel_valid = 1'b0;
  logic [7:0]  fuel_level = '0;
  logic        dist_tick = 1'b0;
  logic        dest_load = 1'b0;
  logic [15:0] dest_dist = '0;
  logic        cpu_overheated;
  logic        gas_tank_empty;
  logic        arrived;
  logic [15:0] remaining_dist;

  vehicle_status_conditioner dut (
    .clk(clk), .reset(reset),
    .temp_valid(temp_valid), .temp_c(temp_c),
    .fuel_valid(fuel_valid), .fuel_level(fuel_level),
    .dist_tick(dist_tick), .dest_load(dest_load), .dest_dist(dest_dist),
    .cpu_overheated(cpu_overheated), .gas_tank_empty(gas_tank_empty),
    .arrived(arrived), .remaining_dist(remaining_dist)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        oh;
    logic        ge;
    logic        ar;
    logic [15:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Reference model: streak of consecutive samples arguing against the current flag.
  bit m_oh, m_ge;
  int hot_streak, fuel_streak, m_rem;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_overheated", int'(cpu_overheated), int'(e.oh));
        chk("gas_tank_empty", int'(gas_tank_empty), int'(e.ge));
        chk("arrived", int'(arrived), int'(e.ar));
        chk("remaining_dist", int'(remaining_dist), int'(e.rd));
      end
    end
  end

  task automatic model(input bit rst, input bit tv, input int t, input bit fv, input int f,
                       input bit dt, input bit dl, input int dd);
    bit q;
    if (rst) begin
      m_oh = 0; m_ge = 1; hot_streak = 0; fuel_streak = 0; m_rem = 0;
      return;
    end
    if (tv) begin
      q = m_oh ? (t <= HOT_OFF) : (t >= HOT_ON);
      hot_streak = q ? hot_streak + 1 : 0;
      if (hot_streak == TEMP_CNT) begin m_oh = !m_oh; hot_streak = 0; end
    end
    if (fv) begin
      q = m_ge ? (f >= FUEL_REFILL) : (f <= FUEL_EMPTY);
      fuel_streak = q ? fuel_streak + 1 : 0;
      if (fuel_streak == FUEL_CNT) begin m_ge = !m_ge; fuel_streak = 0; end
    end
    // A trip is in progress exactly when distance remains.
    if (dl) m_rem = dd;
    else if (dt && m_rem > 0) m_rem = m_rem - 1;
  endtask

  task automatic cycle(input bit rst, input bit tv, input int t, input bit fv, input int f,
                       input bit dt, input bit dl, input int dd);
    exp_t e;
    reset = rst; temp_valid = tv; temp_c = 8'(t); fuel_valid = fv; fuel_level = 8'(f);
    dist_tick = dt; dest_load = dl; dest_dist = 16'(dd);
    model(rst, tv, t, fv, f, dt, dl, dd);
    @(posedge clk);
    e.oh = m_oh; e.ge = m_ge; e.ar = (m_rem == 0); e.rd = 16'(m_rem);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle();                cycle(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tsamp(input int t);    cycle(0, 1, t, 0, 0, 0, 0, 0); endtask
  task automatic fsamp(input int f);    cycle(0, 0, 0, 1, f, 0, 0, 0); endtask
  task automatic tick();                cycle(0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic load(input int d);     cycle(0, 0, 0, 0, 0, 0, 1, d); endtask

  initial begin
    int hot_seq[6] = '{95, 95, 85, 95, 95, 95};
    #1;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) idle();

    foreach (hot_seq[i]) tsamp(hot_seq[i]);
    repeat (3) tsamp(79);
    repeat (4) tsamp(85);

    repeat (4) begin fsamp(25); idle(); end
    repeat (3) begin fsamp(10); idle(); end
    fsamp(10);

    load(3);
    repeat (3) tick();
    tick();

    load(5);
    cycle(0, 0, 0, 0, 0, 1, 1, 7);
    tick();
    load(0);
    tick();

    load(4);
    tsamp(95); tsamp(95);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    tsamp(95);
    idle();

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(74, 96),
            ($urandom_range(0, 3) != 0), $urandom_range(4, 26),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 19) == 0), $urandom_range(0, 12));
    end
    reset = 0; temp_valid = 0; fuel_valid = 0; dist_tick = 0; dest_load = 0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
